// File: rtl/microarquitetura_gp3_pkg.sv
// -----------------------------------------------------------------------------
// microarquitetura_gp3_pkg
// Shared constants for the GP3 Avalon-MM peripherals: the register word
// offsets of the key input port and the edge-capture mode selectors.
// No ports; imported by the key input port and its debouncer.
// -----------------------------------------------------------------------------
package microarquitetura_gp3_pkg;

   // word offsets of the key input port register map
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // edge-capture mode selectors
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // width of the debounce timer able to hold 0..cycles without wrapping
   function automatic int debounce_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/microarquitetura_gp3_debounce.sv
// -----------------------------------------------------------------------------
// microarquitetura_gp3_debounce
// Single key line conditioner: 2-FF synchroniser followed by a debounce timer.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with the current stable level; any agreeing sample restarts
// the wait.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   din    in  raw asynchronous key line
//   stable out debounced key level (IDLE_LEVEL out of reset)
// -----------------------------------------------------------------------------
module microarquitetura_gp3_debounce
   import microarquitetura_gp3_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic stable
);

   localparam int                CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   // down-counter: holds the number of further disagreeing samples needed
   // beyond the next one; terminal count (zero) accepts the new level
   logic [CNT_W-1:0] tmr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1      <= IDLE_LEVEL;
         s2      <= IDLE_LEVEL;
         stable  <= IDLE_LEVEL;
         tmr_cnt <= TC_LOAD;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == stable) begin
            tmr_cnt <= TC_LOAD;
         end else if (tmr_cnt == '0) begin
            stable  <= s2;
            tmr_cnt <= TC_LOAD;
         end else begin
            tmr_cnt <= tmr_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/microarquitetura_gp3_keys_in.sv
// -----------------------------------------------------------------------------
// microarquitetura_gp3_keys_in
// Avalon-MM slave input port for the board push-buttons. Each key line is
// synchronised and debounced, edges of the debounced level are captured in a
// sticky write-one-to-clear register, and a masked level interrupt is raised
// while any enabled flag is pending.
//
// Register map (word offsets, bits above WIDTH-1 read 0):
//   0 DATA     RO    debounced key levels
//   1 reserved       reads 0
//   2 IRQMASK  RW    per-bit interrupt enable
//   3 EDGECAP  R/W1C sticky edge flags
//
// Ports:
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   address    in  word offset
//   chipselect in  slave select
//   read_n     in  read strobe, active-low (reads are side-effect free)
//   write_n    in  write strobe, active-low
//   writedata  in  write data
//   readdata   out read data, combinational (zero wait states)
//   irq        out interrupt request, level, active-high
//   in_port    in  raw asynchronous key lines
// -----------------------------------------------------------------------------
module microarquitetura_gp3_keys_in
   import microarquitetura_gp3_pkg::*;
#(
   parameter int   WIDTH           = 5,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1,
   parameter int   EDGE_MODE       = EDGE_FALL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] in_port
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] edgecap_clr;
   logic             wr_en;

   // writedata bits above WIDTH and the read strobe carry no function here
   logic unused_bus;
   assign unused_bus = ^{writedata[31:WIDTH], read_n};

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_key
      microarquitetura_gp3_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .din    (in_port[gi]),
         .stable (stable[gi])
      );
   end

   always_comb begin
      case (EDGE_MODE)
         EDGE_RISE: edge_evt = stable & ~stable_d;
         EDGE_ANY:  edge_evt = stable ^ stable_d;
         default:   edge_evt = ~stable & stable_d;
      endcase
   end

   assign wr_en       = chipselect & ~write_n;
   assign edgecap_clr = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         // stable_d starts at the idle pattern so reset itself never looks
         // like an edge
         stable_d <= {WIDTH{IDLE_LEVEL}};
         irqmask  <= '0;
         edgecap  <= '0;
      end else begin
         stable_d <= stable;
         if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask <= writedata[WIDTH-1:0];
         end
         // a new event on a bit wins over a simultaneous clear of that bit
         edgecap <= (edgecap & ~edgecap_clr) | edge_evt;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = stable;
         ADDR_RSVD:    readdata            = '0;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      endcase
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_microarquitetura_gp3_keys_in.sv
`timescale 1ns/1ps
module tb_microarquitetura_gp3_keys_in;
   import microarquitetura_gp3_pkg::*;

   localparam int WIDTH = 5;

   logic             clk;
   logic             reset;
   logic [1:0]       address;
   logic             chipselect;
   logic             read_n;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic             irq;
   logic [WIDTH-1:0] in_port;

   microarquitetura_gp3_keys_in #(
      .WIDTH           (WIDTH),
      .DEBOUNCE_CYCLES (4),
      .IDLE_LEVEL      (1'b1),
      .EDGE_MODE       (EDGE_FALL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .in_port    (in_port)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // scoreboard entry: either a register read at addr or the irq line
   typedef struct packed {
      logic        is_irq;
      logic [1:0]  addr;
      logic [31:0] exp;
   } sb_t;

   sb_t   sb_q[$];
   string tag_q[$];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic expect_rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      sb_q.push_back('{is_irq: 1'b0, addr: addr, exp: exp});
      tag_q.push_back(tag);
   endtask

   task automatic expect_irq(input string tag, input logic exp);
      sb_q.push_back('{is_irq: 1'b1, addr: 2'd0, exp: {31'd0, exp}});
      tag_q.push_back(tag);
   endtask

   // compare every pending expectation against the DUT in the current cycle
   task automatic drain();
      sb_t   e;
      string t;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         t = tag_q.pop_front();
         if (e.is_irq) begin
            chk_eq(t, {31'd0, irq}, e.exp);
         end else begin
            address = e.addr;
            read_n  = 1'b0;
            #1;
            chk_eq(t, readdata, e.exp);
            read_n  = 1'b1;
         end
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one write strobe, sampled on the next rising edge
   task automatic wr(input logic [1:0] addr, input logic [31:0] data, input logic cs = 1'b1);
      address    = addr;
      writedata  = data;
      chipselect = cs;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      in_port    = 5'h1F;
      address    = 2'd0;
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = '0;
      tick(2);
      reset = 1'b0;

      // reset state
      expect_rd("rst_data", ADDR_DATA, 32'h1F);
      expect_rd("rst_rsvd", ADDR_RSVD, 32'h0);
      expect_rd("rst_mask", ADDR_IRQMASK, 32'h0);
      expect_rd("rst_cap", ADDR_EDGECAP, 32'h0);
      expect_irq("rst_irq", 1'b0);
      drain();

      // clean press of bit 2, cycle 0 is the current cycle
      in_port = 5'h1B;
      for (int c = 1; c <= 5; c++) begin
         tick();
         expect_rd("press_early", ADDR_DATA, 32'h1F);
         drain();
      end
      tick();
      expect_rd("press_data", ADDR_DATA, 32'h1B);
      expect_rd("press_cap_early", ADDR_EDGECAP, 32'h0);
      drain();
      tick();
      expect_rd("press_cap", ADDR_EDGECAP, 32'h04);
      expect_irq("press_irq_masked", 1'b0);
      drain();

      // unmasking a pending flag raises irq right after the write edge
      wr(ADDR_IRQMASK, 32'h04);
      expect_irq("unmask_irq", 1'b1);
      drain();
      wr(ADDR_IRQMASK, 32'h0);
      expect_irq("remask_irq", 1'b0);
      drain();

      // release: no flag in falling mode, old flag stays sticky
      in_port = 5'h1F;
      tick(10);
      expect_rd("release_data", ADDR_DATA, 32'h1F);
      expect_rd("release_cap", ADDR_EDGECAP, 32'h04);
      drain();
      wr(ADDR_EDGECAP, 32'h04, 1'b0);
      expect_rd("w1c_no_cs", ADDR_EDGECAP, 32'h04);
      drain();
      wr(ADDR_EDGECAP, 32'h04);
      expect_rd("w1c_cap", ADDR_EDGECAP, 32'h0);
      drain();

      // glitch of 3 cycles is rejected
      in_port = 5'h1E;
      tick(3);
      in_port = 5'h1F;
      tick(8);
      expect_rd("glitch_data", ADDR_DATA, 32'h1F);
      expect_rd("glitch_cap", ADDR_EDGECAP, 32'h0);
      drain();

      // 6-cycle low is accepted
      in_port = 5'h1E;
      tick(6);
      expect_rd("long_data", ADDR_DATA, 32'h1E);
      drain();
      in_port = 5'h1F;
      tick(10);
      expect_rd("long_release", ADDR_DATA, 32'h1F);
      expect_rd("long_cap", ADDR_EDGECAP, 32'h01);
      drain();
      wr(ADDR_EDGECAP, 32'h01);

      // irq with mask, W1C drops it
      wr(ADDR_IRQMASK, 32'h04);
      expect_rd("mask_rd", ADDR_IRQMASK, 32'h04);
      drain();
      in_port = 5'h1B;
      tick(6);
      expect_irq("irq_before_cap", 1'b0);
      drain();
      tick();
      expect_irq("irq_set", 1'b1);
      drain();
      wr(ADDR_EDGECAP, 32'h04);
      expect_rd("irq_w1c_cap", ADDR_EDGECAP, 32'h0);
      expect_irq("irq_w1c_irq", 1'b0);
      drain();
      in_port = 5'h1F;
      tick(10);
      expect_rd("irq_release_cap", ADDR_EDGECAP, 32'h0);
      expect_irq("irq_release_irq", 1'b0);
      drain();

      // set-wins: W1C of bit 1 lands on the edge that captures a new event
      in_port = 5'h1D;
      tick(7);
      in_port = 5'h1F;
      tick(10);
      expect_rd("col_pre_cap", ADDR_EDGECAP, 32'h02);
      drain();
      in_port = 5'h1D;
      tick(6);
      wr(ADDR_EDGECAP, 32'h02);
      expect_rd("col_cap", ADDR_EDGECAP, 32'h02);
      drain();
      in_port = 5'h1F;
      tick(10);
      wr(ADDR_EDGECAP, 32'h02);
      expect_rd("col_clear", ADDR_EDGECAP, 32'h0);
      drain();

      // writes to read-only / reserved locations, mask upper bits
      wr(ADDR_DATA, 32'h0);
      wr(ADDR_RSVD, 32'hFFFF_FFFF);
      wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
      expect_rd("ro_data", ADDR_DATA, 32'h1F);
      expect_rd("ro_rsvd", ADDR_RSVD, 32'h0);
      expect_rd("mask_width", ADDR_IRQMASK, 32'h1F);
      drain();

      // reset mid-debounce of bit 3
      in_port = 5'h17;
      tick(2);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      expect_rd("mid_mask", ADDR_IRQMASK, 32'h0);
      expect_rd("mid_data0", ADDR_DATA, 32'h1F);
      drain();
      tick(5);
      expect_rd("mid_data5", ADDR_DATA, 32'h1F);
      drain();
      tick();
      expect_rd("mid_data6", ADDR_DATA, 32'h17);
      drain();
      tick();
      expect_rd("mid_cap", ADDR_EDGECAP, 32'h08);
      expect_irq("mid_irq", 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
